// File: rtl/sync_fifo_pkg.sv
// Shared defaults, width helpers and configuration check for the flagged sync FIFO.
// Optional first-word-fall-through read mode is selected by SYNC_FIFO_FWFT_EN.
package sync_fifo_pkg;

  localparam int DEF_WIDTH     = 8;
  localparam int DEF_DEPTH     = 16;
  localparam int DEF_AF_THRESH = DEF_DEPTH - 2;
  localparam int DEF_AE_THRESH = 2;

  function automatic int ptr_w(input int depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

  function automatic int cnt_w(input int depth);
    return $clog2(depth + 1);
  endfunction

  function automatic bit cfg_ok(input int depth, input int af, input int ae);
    return (depth >= 2) && (af >= 1) && (af <= depth) && (ae >= 0) && (ae <= depth - 1);
  endfunction

endpackage

// File: rtl/sync_fifo_ptr.sv
// Pointer register that wraps from DEPTH-1 to 0 by explicit compare, so any DEPTH works.
module sync_fifo_ptr
  import sync_fifo_pkg::*;
#(
  parameter int DEPTH     = DEF_DEPTH,
  parameter int PTR_WIDTH = ptr_w(DEPTH)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 clr,
  input  logic                 inc,
  output logic [PTR_WIDTH-1:0] ptr
);

  localparam logic [PTR_WIDTH-1:0] LAST = PTR_WIDTH'(DEPTH - 1);

  logic [PTR_WIDTH-1:0] ptr_d, ptr_q;

  always_comb begin
    ptr_d = ptr_q;
    if (clr) begin
      ptr_d = '0;
    end else if (inc) begin
      ptr_d = (ptr_q == LAST) ? '0 : ptr_q + PTR_WIDTH'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ptr_q <= '0;
    end else begin
      ptr_q <= ptr_d;
    end
  end

  assign ptr = ptr_q;

endmodule

// File: rtl/sync_fifo_flags.sv
// Parametrised synchronous FIFO with occupancy count, watermark flags, flush and error pulses.
// Define SYNC_FIFO_FWFT_EN for first-word-fall-through reads; default is a registered read.
module sync_fifo_flags
  import sync_fifo_pkg::*;
#(
  parameter  int WIDTH     = DEF_WIDTH,
  parameter  int DEPTH     = DEF_DEPTH,
  parameter  int AF_THRESH = DEPTH - 2,
  parameter  int AE_THRESH = DEF_AE_THRESH,
  localparam int PTR_WIDTH = ptr_w(DEPTH),
  localparam int CNT_WIDTH = cnt_w(DEPTH)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 clr,
  input  logic                 wr_en,
  input  logic [WIDTH-1:0]     wdata,
  input  logic                 rd_en,
  output logic [WIDTH-1:0]     rdata,
  output logic                 full,
  output logic                 empty,
  output logic                 almost_full,
  output logic                 almost_empty,
  output logic [CNT_WIDTH-1:0] count,
  output logic                 wr_err,
  output logic                 rd_err
);

  generate
    if (!cfg_ok(DEPTH, AF_THRESH, AE_THRESH)) begin : g_bad_cfg
      $error("sync_fifo_flags: illegal DEPTH/AF_THRESH/AE_THRESH combination");
    end
  endgenerate

  logic [PTR_WIDTH-1:0] rd_ptr, wr_ptr;
  logic [WIDTH-1:0]     mem [DEPTH];

  logic                 flush, rd_go, wr_go;
  logic [CNT_WIDTH-1:0] count_d, count_q;
  logic                 full_d, full_q, empty_d, empty_q;
  logic                 af_d, af_q, ae_d, ae_q;
  logic                 wr_err_d, wr_err_q, rd_err_d, rd_err_q;

  // A read frees a slot in the same cycle, so a full FIFO still accepts a paired write.
  always_comb begin
    flush    = rst || clr;
    rd_go    = !flush && rd_en && !empty_q;
    wr_go    = !flush && wr_en && (!full_q || rd_go);
    wr_err_d = !flush && wr_en && !wr_go;
    rd_err_d = !flush && rd_en && !rd_go;

    count_d = count_q;
    if (flush) begin
      count_d = '0;
    end else if (wr_go && !rd_go) begin
      count_d = count_q + CNT_WIDTH'(1);
    end else if (rd_go && !wr_go) begin
      count_d = count_q - CNT_WIDTH'(1);
    end

    full_d  = (count_d == CNT_WIDTH'(DEPTH));
    empty_d = (count_d == '0);
    af_d    = (count_d >= CNT_WIDTH'(AF_THRESH));
    ae_d    = (count_d <= CNT_WIDTH'(AE_THRESH));
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      count_q  <= '0;
      full_q   <= 1'b0;
      empty_q  <= 1'b1;
      af_q     <= 1'b0;
      ae_q     <= 1'b1;
      wr_err_q <= 1'b0;
      rd_err_q <= 1'b0;
    end else begin
      count_q  <= count_d;
      full_q   <= full_d;
      empty_q  <= empty_d;
      af_q     <= af_d;
      ae_q     <= ae_d;
      wr_err_q <= wr_err_d;
      rd_err_q <= rd_err_d;
    end
  end

  always_ff @(posedge clk) begin
    if (wr_go) begin
      mem[wr_ptr] <= wdata;
    end
  end

  sync_fifo_ptr #(.DEPTH(DEPTH), .PTR_WIDTH(PTR_WIDTH)) u_wr_ptr (
    .clk (clk),
    .rst (rst),
    .clr (clr),
    .inc (wr_go),
    .ptr (wr_ptr)
  );

  sync_fifo_ptr #(.DEPTH(DEPTH), .PTR_WIDTH(PTR_WIDTH)) u_rd_ptr (
    .clk (clk),
    .rst (rst),
    .clr (clr),
    .inc (rd_go),
    .ptr (rd_ptr)
  );

`ifdef SYNC_FIFO_FWFT_EN
  // Head word is presented directly; content is meaningless while empty.
  assign rdata = mem[rd_ptr];
`else
  logic [WIDTH-1:0] rdata_d, rdata_q;

  always_comb begin
    rdata_d = rd_go ? mem[rd_ptr] : rdata_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rdata_q <= '0;
    end else begin
      rdata_q <= rdata_d;
    end
  end

  assign rdata = rdata_q;
`endif

  assign count        = count_q;
  assign full         = full_q;
  assign empty        = empty_q;
  assign almost_full  = af_q;
  assign almost_empty = ae_q;
  assign wr_err       = wr_err_q;
  assign rd_err       = rd_err_q;

endmodule
